// File: rtl/mips_store_pkg.sv
// mips_store_pkg
// Types shared by the store serializer:
//   size_e   - encoding of the req_size field (byte, halfword, word, reserved)
//   state_e  - serializer FSM states
//   last_idx - index of the final byte lane written for a given store size
package mips_store_pkg;

   typedef enum logic [1:0] {
      SIZE_B   = 2'b00,
      SIZE_H   = 2'b01,
      SIZE_W   = 2'b10,
      SIZE_RSV = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } state_e;

   function automatic logic [1:0] last_idx(input size_e s);
      case (s)
         SIZE_B:  return 2'd0;
         SIZE_H:  return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/store_byte_sel.sv
// store_byte_sel
// Combinational little-endian byte lane select.
// Ports:
//   data     in  32  register value being stored
//   idx      in  2   byte lane index (0 = least significant byte)
//   sel_byte out 8   data[8*idx+7 : 8*idx]
module store_byte_sel (
   input  logic [31:0] data,
   input  logic [1:0]  idx,
   output logic [7:0]  sel_byte
);

   logic [7:0] lanes [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lanes[gi] = data[8*gi +: 8];
      end
   endgenerate

   assign sel_byte = lanes[idx];

endmodule

// File: rtl/store_serializer.sv
// store_serializer
// Breaks a byte/halfword/word store into a sequence of single-byte writes on
// a byte-wide memory port, least significant byte first, at consecutive
// byte addresses (wrapping modulo 2^ADDR_W).
// Optional build macro: STORE_ALIGN_CHECK_EN -- when defined, misaligned
// halfword/word stores are rejected with err instead of being written.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  store request handshake
//   req_addr/size/data   store byte address, size code, register value
//   mem_we/addr/wdata    byte write strobe, address and data
//   mem_ack              memory accepted the current byte
//   done                 one-cycle pulse when the store completes
//   err                  one-cycle pulse when the store is rejected
module store_serializer
   import mips_store_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   output logic              done,
   output logic              err
);

   state_e      state_reg;
   logic [1:0]  idx_reg;
   logic [1:0]  last_reg;
   logic [31:0] data_reg;

   size_e       size_in;
   logic        misaligned;
   logic        reject;
   logic [31:0] sel_data;
   logic [1:0]  idx_next;
   logic [7:0]  sel_byte;

   assign size_in = size_e'(req_size);

`ifdef STORE_ALIGN_CHECK_EN
   assign misaligned = ((size_in == SIZE_H) && req_addr[0]) ||
                       ((size_in == SIZE_W) && (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign reject = (size_in == SIZE_RSV) || misaligned;

   // The byte selector serves two cases: lane 0 of the incoming request on
   // the handshake, and the next lane of the latched data on each ack.
   // This lets mem_wdata be registered together with mem_addr.
   assign sel_data = (state_reg == IDLE) ? req_data : data_reg;
   assign idx_next = (state_reg == IDLE) ? 2'd0 : idx_reg + 2'd1;

   store_byte_sel u_byte_sel (
      .data     (sel_data),
      .idx      (idx_next),
      .sel_byte (sel_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= 2'd0;
         last_reg  <= 2'd0;
         data_reg  <= 32'd0;
         req_ready <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (reject) begin
                     state_reg <= ERR;
                     err       <= 1'b1;
                  end else begin
                     state_reg <= WRITE;
                     idx_reg   <= 2'd0;
                     last_reg  <= last_idx(size_in);
                     data_reg  <= req_data;
                     mem_we    <= 1'b1;
                     mem_addr  <= req_addr;
                     mem_wdata <= sel_byte;
                  end
               end
            end
            WRITE: begin
               // Address and data only move on ack, so they hold while
               // the memory stalls.
               if (mem_ack) begin
                  if (idx_reg == last_reg) begin
                     state_reg <= DONE;
                     mem_we    <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     idx_reg   <= idx_next;
                     mem_addr  <= mem_addr + ADDR_W'(1);
                     mem_wdata <= sel_byte;
                  end
               end
            end
            DONE, ERR: begin
               state_reg <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state_reg <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_serializer.sv
// tb_store_serializer
// Scoreboard bench for store_serializer: expected byte writes are queued when
// a request is driven and compared as the memory port accepts them.
module tb_store_serializer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_data;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic        done;
   logic        err;

   int n_vec;
   int n_miscmp;
   int ack_delay;
   int wait_cnt;

   logic [39:0] exp_q[$];   // {addr, byte}

   store_serializer #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_data  (req_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Memory model: acks each byte after ack_delay stall cycles.
   initial begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_we) begin
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
            end else begin
               mem_ack  = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Write monitor: scoreboard compare plus stall stability.
   logic        prev_we, prev_ack;
   logic [31:0] prev_addr;
   logic [7:0]  prev_data;
   initial begin
      prev_we = 1'b0;
      prev_ack = 1'b0;
      prev_addr = '0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_we && !prev_ack && mem_we) begin
               check("hold_addr", mem_addr, prev_addr);
               check("hold_data", {24'd0, mem_wdata}, {24'd0, prev_data});
            end
            if (mem_we && mem_ack) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", mem_addr, 32'hFFFF_FFFF ^ mem_addr);
               end else begin
                  logic [39:0] e;
                  e = exp_q.pop_front();
                  check("wr_addr", mem_addr, e[39:8]);
                  check("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
               end
            end
         end
         prev_we   = mem_we;
         prev_ack  = mem_ack;
         prev_addr = mem_addr;
         prev_data = mem_wdata;
      end
   end

   task automatic send(input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] data, input int d, input bit exp_err);
      int nbytes;
      int cycles;
      int exp_lat;
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      if (exp_err) nbytes = 0;
      exp_lat = exp_err ? 1 : nbytes * (d + 1) + 1;
      ack_delay = d;
      for (int i = 0; i < nbytes; i++) begin
         logic [31:0] a;
         logic [7:0]  b;
         a = addr + i;
         b = 8'((data >> (8 * i)) & 32'hFF);
         exp_q.push_back({a, b});
      end
      @(negedge clk);
      check("ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_size  = size;
      req_data  = data;
      @(negedge clk);
      req_valid = 1'b0;
      req_data  = 32'hDEAD_BEEF;
      cycles = 1;
      if (exp_err) check("no_we", {31'd0, mem_we}, 32'd0);
      while (!done && !err && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      check("end_event", {31'd0, done | err}, 32'd1);
      check("err_flag", {31'd0, err}, {31'd0, exp_err});
      check("done_flag", {31'd0, done}, {31'd0, !exp_err});
      check("latency", cycles, exp_lat);
      check("pending_writes", exp_q.size(), 32'd0);
      $display("txn addr=%h size=%0d data=%h ack_delay=%0d err=%0d latency=%0d",
               addr, size, data, d, err, cycles);
      @(negedge clk);
      check("pulse_end", {30'd0, done, err}, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
      exp_q.delete();
   endtask

   bit align_chk;

   initial begin
      n_vec = 0;
      n_miscmp = 0;
      ack_delay = 0;
`ifdef STORE_ALIGN_CHECK_EN
      align_chk = 1'b1;
`else
      align_chk = 1'b0;
`endif
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      req_size = '0;
      req_data = '0;
      repeat (3) @(negedge clk);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_done_err", {30'd0, done, err}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);

      send(32'h0000_0100, 2'b10, 32'hAABB_CCDD, 0, 1'b0);
      send(32'h0000_0007, 2'b00, 32'h1234_56EF, 0, 1'b0);
      send(32'h0000_0010, 2'b01, 32'hFFFF_8001, 3, 1'b0);
      send(32'h0000_0020, 2'b11, 32'h5555_5555, 0, 1'b1);
      send(32'h0000_0102, 2'b10, 32'h0403_0201, 1, align_chk);
      send(32'hFFFF_FFFF, 2'b01, 32'h0000_BEEF, 0, align_chk);
      send(32'h0000_0040, 2'b10, 32'h8877_6655, 2, 1'b0);

      // Reset after the second byte of a word store.
      ack_delay = 0;
      exp_q.push_back({32'h0000_0200, 8'h44});
      exp_q.push_back({32'h0000_0201, 8'h33});
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h0000_0200;
      req_size  = 2'b10;
      req_data  = 32'h1122_3344;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_we", {31'd0, mem_we}, 32'd0);
      check("abort_done", {30'd0, done, err}, 32'd0);
      check("abort_addr", mem_addr, 32'd0);
      check("abort_writes", exp_q.size(), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("abort_quiet", {29'd0, mem_we, done, err}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_nodone", {30'd0, done, err}, 32'd0);
      exp_q.delete();

      send(32'h0000_0300, 2'b00, 32'h0000_005A, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
